// File: rtl/writeback_stage.sv
// Final pipeline stage: retires instructions from the memory stage and drives
// the registered register-file write port, plus halt, retire count and timeout.
module writeback_stage #(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_wbSel,
  input  logic             in_regWrite,
  input  logic [2:0]       in_wrReg,
  input  logic [WIDTH-1:0] in_aluRes,
  input  logic [WIDTH-1:0] in_pc2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_halt,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             mem_done,
  output logic [WIDTH-1:0] writeData,
  output logic [2:0]       wrReg,
  output logic             regWrite,
  output logic             halted,
  output logic [15:0]      retired,
  output logic             err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, HALTED} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       pend_reg;
  logic             pend_we;
  logic             accept;
  logic             commit;
  logic             commit_we;
  logic [WIDTH-1:0] commit_data;
  logic [2:0]       commit_reg;
  logic             start_wait;
  logic             halt_acc;
  logic             timeout;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // HALT outranks the source select; a MEM read that completes in its accept
  // cycle commits directly without visiting WAIT_MEM.
  always_comb begin
    state_nxt   = state;
    commit      = 1'b0;
    commit_we   = 1'b0;
    commit_data = in_aluRes;
    commit_reg  = in_wrReg;
    start_wait  = 1'b0;
    halt_acc    = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_halt) begin
            halt_acc  = 1'b1;
            state_nxt = HALTED;
          end else if (in_wbSel == 2'b01 && !mem_done) begin
            start_wait = 1'b1;
            state_nxt  = WAIT_MEM;
          end else begin
            commit    = 1'b1;
            commit_we = in_regWrite;
            case (in_wbSel)
              2'b00:   commit_data = in_aluRes;
              2'b01:   commit_data = mem_data;
              2'b10:   commit_data = in_pc2;
              default: commit_data = in_imm;
            endcase
          end
        end
      end
      WAIT_MEM: begin
        if (mem_done) begin
          commit      = 1'b1;
          commit_we   = pend_we;
          commit_data = mem_data;
          commit_reg  = pend_reg;
          state_nxt   = IDLE;
        end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // The write enable is a one-cycle pulse; data and select hold between commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeData <= '0;
      wrReg     <= '0;
      regWrite  <= 1'b0;
      halted    <= 1'b0;
      retired   <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      pend_reg  <= '0;
      pend_we   <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      if (commit) begin
        writeData <= commit_data;
        wrReg     <= commit_reg;
        regWrite  <= commit_we;
      end
      if (commit || halt_acc) retired <= retired + 16'd1;
      if (halt_acc) halted <= 1'b1;
      if (start_wait) begin
        pend_reg <= in_wrReg;
        pend_we  <= in_regWrite;
        cnt      <= '0;
      end else if (state == WAIT_MEM && !mem_done && !timeout) begin
        cnt <= cnt + CW'(1);
      end
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the WISC-552 datapath; it is the writer side of the register-file port that the decode stage reads.
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- Selects the writeback source and waits on multi-cycle memory reads.
- Drives the registered writeData/wrReg/regWrite triple into the register file.
- Also tracks halt, retired-instruction count and a memory-timeout error.

Parameters:
WIDTH, 16, datapath and register width
MEM_TIMEOUT, 15, max cycles spent in WAIT_MEM before timeout error

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept this cycle
in_wbSel  input  2  source select: 00 ALU, 01 MEM, 10 PC+2, 11 IMM
in_regWrite  input  1  instruction writes a register
in_wrReg  input  3  destination register number
in_aluRes  input  WIDTH  ALU result
in_pc2  input  WIDTH  PC+2 (JAL/JALR link value)
in_imm  input  WIDTH  extended immediate (LBI/SLBI)
in_halt  input  1  instruction is HALT
mem_data  input  WIDTH  data-memory read data
mem_done  input  1  mem_data valid this cycle
writeData  output  WIDTH  register-file write data
wrReg  output  3  register-file write select
regWrite  output  1  register-file write enable
halted  output  1  HALT has retired
retired  output  16  count of retired instructions
err  output  1  sticky memory-timeout error

Behaviour:
- States: IDLE, WAIT_MEM, HALTED.
- Reset (rst=0, asynchronous) forces all of the following:
  - state=IDLE;
  - regWrite=0, writeData=0, wrReg=0;
  - halted=0, retired=0, err=0;
  - timeout counter=0.
  - Any pending memory wait is dropped and no write is issued.
- in_ready is combinational: 1 only in IDLE; 0 in WAIT_MEM and HALTED.
- Acceptance occurs when in_valid && in_ready at a rising edge.
- IDLE, accept with wbSel != 01:
  - At that edge, register writeData = selected source and wrReg = in_wrReg.
  - regWrite = in_regWrite for exactly the next cycle; retired increments.
  - Back-to-back accepts give one commit per cycle.
- IDLE, accept with wbSel = 01 and mem_done=1 the same cycle: same as above, with writeData = mem_data.
- IDLE, accept with wbSel = 01 and mem_done=0:
  - Latch wrReg/regWrite intent; go to WAIT_MEM; counter=0; regWrite=0.
- WAIT_MEM:
  - Each cycle with mem_done=0: counter increments.
  - On the first cycle with mem_done=1: writeData=mem_data, regWrite=latched intent for one cycle, retired increments, return to IDLE.
  - If counter reaches MEM_TIMEOUT without mem_done: err=1 (sticky until reset), return to IDLE, no write, retired unchanged.
- mem_done outside a pending MEM read is ignored.
- in_halt accepted:
  - No register write, even if in_regWrite=1.
  - retired increments; halted=1 from the next cycle; state=HALTED.
- HALTED is absorbing until reset: in_ready=0, regWrite=0, outputs held.
- Outside a commit cycle, regWrite=0; writeData/wrReg hold their last values.
- retired wraps 0xFFFF -> 0x0000.
- Writes to any register, including R7, are passed through unchanged. Write-before-read bypass is the register file's job.

Test Plan:
- Reset, then accept ALU op (aluRes=0x1234, wrReg=3, regWrite=1) -> next cycle regWrite=1, wrReg=3, writeData=0x1234; retired=1; following cycle regWrite=0.
- Three back-to-back accepts: PC+2=0x0042 to R7, IMM=0xFF80 to R1, ALU with regWrite=0 -> commits on consecutive cycles with those values; the third has regWrite=0; retired=3; in_ready stays 1.
- MEM load to R5 with mem_done low for 4 cycles, then mem_data=0xBEEF with mem_done=1:
  - in_ready=0 during the wait;
  - one cycle after mem_done: regWrite=1, wrReg=5, writeData=0xBEEF;
  - then IDLE.
- MEM load with mem_done never asserted -> after 15 wait cycles err=1, no regWrite pulse, in_ready returns to 1; err persists across later normal commits.
- HALT with in_regWrite=1 -> no write; halted=1 next cycle; in_ready=0 while in_valid stays high for 10 cycles; retired stops.
- Assert rst=0 mid-WAIT_MEM, asynchronously between clock edges -> outputs clear immediately; after release a late mem_done causes no write and in_ready=1.
